// File: rtl/master_bus_port.sv
// master_bus_port: per-master burst sequencer between core and bus controller.
// Define MBP_ACK_TIMEOUT_EN to bound ACK_WAIT by ACK_TIMEOUT cycles (status 10).
module master_bus_port #(
  parameter int LEN_W = 8,
  parameter int ACK_TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [1:0]       slave_sel,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             core_done,
  output logic [1:0]       status,
  input  logic             slave_ack,
  input  logic             slave_nak,
  input  logic             beat_fire,
  output logic             last,
  output logic             hold,
  output logic [1:0]       id,
  output logic [1:0]       com_state,
  output logic             done,
  input  logic [1:0]       cmd
);
  typedef enum logic [2:0] {IDLE, REQ, ACK_WAIT, COM, SUSP, END, NAK} state_t;
  localparam logic [1:0] WAIT = 2'b00, STOP_S = 2'b01, STOP_P = 2'b10, CLEAR = 2'b11;
  state_t state, state_n;
  logic [LEN_W-1:0] remaining, rem_n;
  logic [1:0] id_n, res, res_n, status_n;
  logic core_done_n, to_hit;
`ifdef MBP_ACK_TIMEOUT_EN
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) cnt <= '0;
    else cnt <= (state == ACK_WAIT) ? cnt + 1'b1 : '0;
  assign to_hit = (state == ACK_WAIT) && (cnt == TW'(ACK_TIMEOUT - 1));
`else
  assign to_hit = 1'b0 && (ACK_TIMEOUT > 0);
`endif
  // res holds the pending outcome; status only changes together with core_done
  always_comb begin
    state_n = state;
    id_n = id;
    rem_n = remaining;
    res_n = res;
    status_n = status;
    core_done_n = 1'b0;
    case (state)
      IDLE: if (start && slave_sel != 2'd0 && burst_len != '0) begin
        state_n = REQ;
        id_n = slave_sel;
        rem_n = burst_len;
      end
      REQ: if (cmd == CLEAR) begin
        state_n = ACK_WAIT;
        id_n = 2'd0;
      end
      ACK_WAIT:
        if (slave_nak) begin state_n = NAK; res_n = 2'b01; end
        else if (cmd == STOP_P) begin state_n = END; res_n = 2'b11; end
        else if (slave_ack) state_n = COM;
        else if (to_hit) begin state_n = NAK; res_n = 2'b10; end
      COM: begin
        if (beat_fire) rem_n = remaining - 1'b1;
        if (cmd == STOP_P) begin state_n = END; res_n = 2'b11; end
        else if (beat_fire && remaining == LEN_W'(1)) begin state_n = END; res_n = 2'b00; end
        else if (cmd == STOP_S) state_n = SUSP;
      end
      SUSP:
        if (cmd == CLEAR) state_n = COM;
        else if (cmd == STOP_P) begin state_n = END; res_n = 2'b11; end
      END, NAK: if (cmd == WAIT) begin
        state_n = IDLE;
        core_done_n = 1'b1;
        status_n = res;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      id <= 2'd0;
      remaining <= '0;
      res <= 2'b00;
      status <= 2'b00;
      core_done <= 1'b0;
    end else begin
      state <= state_n;
      id <= id_n;
      remaining <= rem_n;
      res <= res_n;
      status <= status_n;
      core_done <= core_done_n;
    end
  assign busy = state != IDLE;
  assign last = (state == COM) && (remaining == LEN_W'(1));
  assign hold = state == SUSP;
  assign done = (state == END) || (state == NAK);
  assign com_state = (state == ACK_WAIT) ? 2'b10 :
                     (state == COM || state == SUSP) ? 2'b11 :
                     (state == NAK) ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_master_bus_port.sv
// tb_master_bus_port: directed stimulus, per-cycle model compare plus literal spot checks.
module tb_master_bus_port;
  localparam int LEN_W = 8;
  localparam int TO = 10;
`ifdef MBP_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rstN = 1'b0, start = 1'b0, slave_ack = 1'b0, slave_nak = 1'b0, beat_fire = 1'b0;
  logic [1:0] slave_sel = 2'd0, cmd = 2'd0;
  logic [LEN_W-1:0] burst_len = '0;
  logic busy, core_done, last, hold, done;
  logic [1:0] status, id, com_state;
  int checks = 0, failures = 0;
  bit en = 1'b0;

  master_bus_port #(.LEN_W(LEN_W), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rstN(rstN), .start(start), .slave_sel(slave_sel), .burst_len(burst_len),
    .busy(busy), .core_done(core_done), .status(status), .slave_ack(slave_ack),
    .slave_nak(slave_nak), .beat_fire(beat_fire), .last(last), .hold(hold), .id(id),
    .com_state(com_state), .done(done), .cmd(cmd)
  );

  always #5 clk = ~clk;

  // Reference: transaction phase, beats left, pending outcome and published status
  typedef enum int {P_IDLE, P_REQ, P_AW, P_COM, P_SUSP, P_FIN, P_NAK} ph_t;
  ph_t ph;
  int mid, mrem, mres, mstat, mcd, mwait, left;

  always @(posedge clk or negedge rstN)
    if (!rstN) begin
      ph <= P_IDLE; mid <= 0; mrem <= 0; mres <= 0; mstat <= 0; mcd <= 0; mwait <= 0;
    end else begin
      mcd <= 0;
      if (ph == P_IDLE && start && slave_sel != 0 && burst_len != 0) begin
        ph <= P_REQ; mid <= int'(slave_sel); mrem <= int'(burst_len);
      end else if (ph == P_REQ && cmd == 2'd3) begin
        ph <= P_AW; mid <= 0; mwait <= 0;
      end else if (ph == P_AW) begin
        mwait <= mwait + 1;
        if (slave_nak) begin ph <= P_NAK; mres <= 1; end
        else if (cmd == 2'd2) begin ph <= P_FIN; mres <= 3; end
        else if (slave_ack) ph <= P_COM;
        else if (TO_EN && mwait + 1 >= TO) begin ph <= P_NAK; mres <= 2; end
      end else if (ph == P_COM) begin
        left = mrem - (beat_fire ? 1 : 0);
        mrem <= left;
        if (cmd == 2'd2) begin ph <= P_FIN; mres <= 3; end
        else if (left == 0) begin ph <= P_FIN; mres <= 0; end
        else if (cmd == 2'd1) ph <= P_SUSP;
      end else if (ph == P_SUSP) begin
        if (cmd == 2'd3) ph <= P_COM;
        else if (cmd == 2'd2) begin ph <= P_FIN; mres <= 3; end
      end else if ((ph == P_FIN || ph == P_NAK) && cmd == 2'd0) begin
        ph <= P_IDLE; mcd <= 1; mstat <= mres;
      end
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int ecom(ph_t p);
    return p == P_AW ? 2 : (p == P_COM || p == P_SUSP) ? 3 : p == P_NAK ? 1 : 0;
  endfunction

  always @(negedge clk)
    if (en) begin
      chk("m_busy", 32'(busy), 32'(ph != P_IDLE));
      chk("m_core_done", 32'(core_done), 32'(mcd));
      chk("m_status", 32'(status), 32'(mstat));
      chk("m_last", 32'(last), 32'(ph == P_COM && mrem == 1));
      chk("m_hold", 32'(hold), 32'(ph == P_SUSP));
      chk("m_id", 32'(id), 32'(mid));
      chk("m_com_state", 32'(com_state), 32'(ecom(ph)));
      chk("m_done", 32'(done), 32'(ph == P_FIN || ph == P_NAK));
    end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic req(input logic [1:0] sel, input logic [LEN_W-1:0] len);
    start = 1'b1; slave_sel = sel; burst_len = len;
    cyc();
    start = 1'b0; slave_sel = 2'd0; burst_len = '0;
  endtask

  task automatic go_com(input logic [1:0] sel, input logic [LEN_W-1:0] len);
    req(sel, len);
    cmd = 2'd3; cyc(); cmd = 2'd0;
    slave_ack = 1'b1; cyc(); slave_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_com", 32'(com_state), 0);
    chk("rst_status", 32'(status), 0);
    rstN = 1'b1; en = 1'b1;
    cyc();
    // invalid requests are dropped
    req(2'd0, 8'd5); chk("inv_sel", 32'(busy), 0);
    req(2'd2, 8'd0); chk("inv_len", 32'(busy), 0);
    // normal burst
    req(2'd2, 8'd3);
    chk("n_id", 32'(id), 2); chk("n_busy", 32'(busy), 1);
    cmd = 2'd3; cyc(); cmd = 2'd0;
    chk("n_id_clr", 32'(id), 0); chk("n_aw", 32'(com_state), 2);
    slave_ack = 1'b1; cyc(); slave_ack = 1'b0;
    chk("n_com", 32'(com_state), 3); chk("n_last0", 32'(last), 0);
    start = 1'b1; slave_sel = 2'd1; burst_len = 8'd5;
    beat_fire = 1'b1; cyc(); start = 1'b0; slave_sel = 2'd0; burst_len = '0;
    chk("n_busy_start", 32'(id), 0);
    cyc(); chk("n_last", 32'(last), 1);
    cyc(); beat_fire = 1'b0;
    chk("n_done", 32'(done), 1); chk("n_end", 32'(com_state), 0);
    cyc(); chk("n_cd", 32'(core_done), 1); chk("n_status", 32'(status), 0);
    cyc(); chk("n_cd_pulse", 32'(core_done), 0);
    // nak
    req(2'd1, 8'd4); cmd = 2'd3; cyc(); cmd = 2'd0;
    slave_nak = 1'b1; cyc(); slave_nak = 1'b0;
    chk("k_com", 32'(com_state), 1); chk("k_done", 32'(done), 1);
    cyc(); chk("k_status", 32'(status), 1);
    // simultaneous ack and nak
    req(2'd1, 8'd4); cmd = 2'd3; cyc(); cmd = 2'd0;
    slave_nak = 1'b1; slave_ack = 1'b1; cyc(); slave_nak = 1'b0; slave_ack = 1'b0;
    chk("an_com", 32'(com_state), 1);
    cyc(); chk("an_status", 32'(status), 1);
    // suspend and resume
    go_com(2'd3, 8'd4);
    beat_fire = 1'b1; cyc(2); beat_fire = 1'b0;
    cmd = 2'd1; cyc(); chk("s_hold", 32'(hold), 1);
    beat_fire = 1'b1; cyc(4); chk("s_hold4", 32'(hold), 1);
    cmd = 2'd3; beat_fire = 1'b0; cyc(); cmd = 2'd0;
    chk("s_resume", 32'(com_state), 3); chk("s_last0", 32'(last), 0);
    beat_fire = 1'b1; cyc(); chk("s_last", 32'(last), 1);
    cyc(); beat_fire = 1'b0; chk("s_done", 32'(done), 1);
    cyc(); chk("s_status", 32'(status), 0);
    // preempt
    go_com(2'd2, 8'd8);
    beat_fire = 1'b1; cyc(3); beat_fire = 1'b0;
    cmd = 2'd2; cyc(); cmd = 2'd0;
    chk("p_done", 32'(done), 1); chk("p_end", 32'(com_state), 0);
    cyc(); chk("p_status", 32'(status), 3);
    // ack timeout
    req(2'd2, 8'd1); cmd = 2'd3; cyc(); cmd = 2'd0;
    if (TO_EN) begin
      cyc(9); chk("t_wait", 32'(com_state), 2);
      cyc(); chk("t_nak", 32'(com_state), 1);
      cyc(); chk("t_status", 32'(status), 2);
    end else begin
      cyc(200); chk("t_wait", 32'(com_state), 2);
      cmd = 2'd2; cyc(); cmd = 2'd0;
      cyc(); chk("t_status", 32'(status), 3);
    end
    // async reset mid-burst
    go_com(2'd1, 8'd4);
    beat_fire = 1'b1; cyc(); beat_fire = 1'b0;
    #2 rstN = 1'b0; #1;
    chk("r_busy", 32'(busy), 0); chk("r_com", 32'(com_state), 0);
    chk("r_status", 32'(status), 0); chk("r_done", 32'(done), 0);
    #2 rstN = 1'b1;
    cyc(); chk("r_cd", 32'(core_done), 0);
    go_com(2'd3, 8'd1);
    chk("r_last", 32'(last), 1);
    beat_fire = 1'b1; cyc(); beat_fire = 1'b0;
    cyc(); chk("r_cd2", 32'(core_done), 1); chk("r_status2", 32'(status), 0);
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/master_bus_port.md
# master_bus_port

Per-master transaction sequencer sitting between a master core and the central bus controller. Accepts a burst request (target slave, beat count) from the core, publishes the slave id to the controller, and drives the controller-facing `com_state`/`done` handshake through request, acknowledge, transfer and release. It follows the controller's `cmd` (grant, suspend, preempt, release) and returns a completion status to the core. One instance per master.

## Interface
- `LEN_W`, 8, width of burst length / beat counter
- `ACK_TIMEOUT`, 100, cycles allowed in ACK_WAIT before forced nak (only with `MBP_ACK_TIMEOUT_EN`)
- `clk`  in  1  clock
- `rstN`  in  1  reset, asynchronous, active-low
- `start`  in  1  core request pulse; sampled only in IDLE
- `slave_sel`  in  2  target slave id; 0 = invalid
- `burst_len`  in  LEN_W  beats in burst; 0 = invalid
- `busy`  out  1  high in any state except IDLE
- `core_done`  out  1  one-cycle pulse when transaction retires
- `status`  out  2  00 ok, 01 nak, 10 timeout, 11 aborted; valid with `core_done`, held until next `core_done`
- `slave_ack`  in  1  slave accepted address phase
- `slave_nak`  in  1  slave refused
- `beat_fire`  in  1  one data beat completed (valid&ready) this cycle
- `last`  out  1  current beat is final beat
- `hold`  out  1  bus side must stall (suspended)
- `id`  out  2  requested slave id to controller
- `com_state`  out  2  00 end_com, 01 nak, 10 wait_ack, 11 com
- `done`  out  1  transaction finished, awaiting release
- `cmd`  in  2  from controller: 00 WAIT, 01 STOP_S, 10 STOP_P, 11 CLEAR

## Operation
- States: IDLE, REQ, ACK_WAIT, COM, SUSP, END, NAK.
- IDLE: `com_state`=00. `start`&&`slave_sel`!=0&&`burst_len`!=0 -> latch sel/len into `remaining`; `id`<=`slave_sel`; -> REQ. Invalid request is ignored; no `core_done` is produced.
- REQ: `id` held. `cmd`==CLEAR -> `id`<=0, -> ACK_WAIT.
- ACK_WAIT: `com_state`=10. Transitions are evaluated in this order:
  - `slave_nak` -> NAK, status 01 (nak wins over a simultaneous ack);
  - `cmd`==STOP_P -> END, status 11;
  - `slave_ack` -> COM;
  - timeout -> NAK, status 10.
- COM: `com_state`=11. `last`=(`remaining`==1). Each `beat_fire` decrements `remaining`. `beat_fire` with `remaining`==1 -> END, status 00.
- COM under `cmd`: STOP_S -> SUSP; STOP_P -> END, status 11. A beat firing in the same cycle as STOP_P is counted but ignored for status.
- SUSP: `com_state`=11, `hold`=1, `beat_fire` ignored, `remaining` frozen. `cmd`==CLEAR -> COM; `cmd`==STOP_P -> END, status 11.
- END: `com_state`=00, `done`=1. `cmd`==WAIT -> IDLE, `core_done` pulse.
- NAK: `com_state`=01, `done`=1. `cmd`==WAIT -> IDLE, `core_done` pulse.
- `start` while `busy` is ignored (no queueing).
- `id` clears on leaving REQ, so the controller never re-allocates the same request after release.

## Timing
- Reset values:
  - state IDLE;
  - `id`=0, `com_state`=00, `done`=0, `busy`=0, `core_done`=0, `status`=00, `last`=0, `hold`=0, `remaining`=0.
- All outputs are registered or decoded from registered state; no combinational path from `cmd`/`slave_*` to outputs.
- `start` at cycle n -> `id` valid and `busy`=1 at n+1.
- `cmd`==CLEAR sampled at n -> `id`=0 and `com_state`=10 at n+1.
- `slave_ack` at n -> `com_state`=11 at n+1. First beat may fire at n+1.
- Final `beat_fire` at n -> `com_state`=00 and `done`=1 at n+1.
- `cmd`==WAIT at m -> IDLE and `core_done`=1 at m+1. A new `start` is accepted from m+1.
- Timeout counter clears on entry to ACK_WAIT. NAK is reached the cycle after the count hits `ACK_TIMEOUT`-1 with no ack/nak.
- `rstN` low mid-transaction: immediate return to reset values; no `core_done`.

## Configuration
- `MBP_ACK_TIMEOUT_EN` defined: timeout counter (width clog2(`ACK_TIMEOUT`)) present; status 10 is reachable.
- Not defined: no counter; ACK_WAIT waits indefinitely for ack/nak/STOP_P; status 10 is never produced.

## Test plan
- Normal burst: start, sel=2, len=3; CLEAR; ack; 3 beats; WAIT -> `id`=2 then 0, `com_state` 10->11->00, `last` on beat 3, `core_done` with status 00.
- Nak: sel=1, len=4, CLEAR, `slave_nak` -> `com_state`=01, `done`=1; WAIT -> status 01. Ack+nak in the same cycle -> also status 01.
- Suspend/resume: len=4, STOP_S after beat 2 for 5 cycles with `beat_fire` high throughout -> `hold`=1, `remaining` stays 2; CLEAR -> 2 more beats complete, status 00.
- Preempt: len=8, STOP_P after beat 3 -> END next cycle, `done`=1; WAIT -> status 11.
- Timeout (macro on, `ACK_TIMEOUT`=10): no ack for 10 cycles after CLEAR -> NAK, status 10. Macro off: still in ACK_WAIT after 200 cycles.
- Async reset in COM after 1 beat, then fresh start sel=3, len=1 -> all outputs at reset values immediately; new burst completes with status 00.
